// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// 10G RX link sequencer: aligner reset pulse, lock wait with timeout, BER windows
// and forced re-align on persistent high BER or a management restart.
module eth_phy_10g_rx_link_ctrl #(
   parameter int unsigned HDR_WIDTH      = 2,
   parameter int unsigned BER_WINDOW     = 19531,
   parameter int unsigned BER_THRESH     = 16,
   parameter int unsigned LOCK_TIMEOUT   = 65535,
   parameter int unsigned RST_PULSE      = 4,
   parameter int unsigned HI_BER_WINDOWS = 4,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HDR_WIDTH-1:0] i_serdes_rx_hdr_align,
   input  logic                 i_rx_block_lock,
   input  logic                 i_restart,
   output logic                 o_aligner_rst,
   output logic                 o_rx_hi_ber,
   output logic                 o_rx_status,
   output logic [CNT_WIDTH-1:0] o_relock_count,
   output logic [1:0]           o_state
);

   localparam int unsigned RST_W  = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
   localparam int unsigned LOCK_W = $clog2(LOCK_TIMEOUT);
   localparam int unsigned WIN_W  = $clog2(BER_WINDOW);
   localparam int unsigned HBW_W  = $clog2(HI_BER_WINDOWS + 1);
   localparam int unsigned BER_W  = 8;

   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_PULSE - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(BER_WINDOW - 1);
   localparam logic [HBW_W-1:0]  HBW_LAST  = HBW_W'(HI_BER_WINDOWS - 1);
   localparam logic [BER_W-1:0]  BER_THR   = BER_W'(BER_THRESH);

   typedef enum logic [1:0] {
      ST_RESET     = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_LOCKED    = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [RST_W-1:0]    rst_tmr_q, rst_tmr_d;
   logic [LOCK_W-1:0]   lock_tmr_q, lock_tmr_d;
   logic [WIN_W-1:0]    win_tmr_q, win_tmr_d;
   logic [BER_W-1:0]    ber_cnt_q, ber_cnt_d;
   logic [BER_W-1:0]    ber_next;
   logic [HBW_W-1:0]    hbw_cnt_q, hbw_cnt_d;
   logic                hi_ber_q, hi_ber_d;
   logic                aligner_rst_q, aligner_rst_d;
   logic                status_q, status_d;
   logic [CNT_WIDTH-1:0] relock_q, relock_d;
   logic                hdr_inv;
   logic                relock_inc;

   assign hdr_inv = (i_serdes_rx_hdr_align != HDR_WIDTH'(1)) &&
                    (i_serdes_rx_hdr_align != HDR_WIDTH'(2));
   assign ber_next = (hdr_inv && (ber_cnt_q != BER_THR)) ? ber_cnt_q + 1'b1 : ber_cnt_q;

   always_comb begin
      state_d    = state_q;
      rst_tmr_d  = rst_tmr_q;
      lock_tmr_d = lock_tmr_q;
      win_tmr_d  = win_tmr_q;
      ber_cnt_d  = ber_cnt_q;
      hbw_cnt_d  = hbw_cnt_q;
      hi_ber_d   = hi_ber_q;
      relock_inc = 1'b0;

      unique case (state_q)
         ST_RESET: begin
            if (rst_tmr_q == RST_LAST) state_d = ST_WAIT_LOCK;
            else                       rst_tmr_d = rst_tmr_q + 1'b1;
         end
         ST_WAIT_LOCK: begin
            if (i_rx_block_lock) begin
               state_d = ST_LOCKED;
            end else if (lock_tmr_q == LOCK_LAST) begin
               state_d    = ST_RESET;
               relock_inc = 1'b1;
            end else begin
               lock_tmr_d = lock_tmr_q + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!i_rx_block_lock) begin
               state_d = ST_WAIT_LOCK;
            end else if (win_tmr_q == WIN_LAST) begin
               // The wrap-cycle header belongs to the closing window.
               win_tmr_d = '0;
               ber_cnt_d = '0;
               if (ber_next < BER_THR) begin
                  hi_ber_d  = 1'b0;
                  hbw_cnt_d = '0;
               end else begin
                  hi_ber_d = 1'b1;
                  if (hbw_cnt_q == HBW_LAST) begin
                     state_d    = ST_RESET;
                     relock_inc = 1'b1;
                  end else begin
                     hbw_cnt_d = hbw_cnt_q + 1'b1;
                  end
               end
            end else begin
               win_tmr_d = win_tmr_q + 1'b1;
               ber_cnt_d = ber_next;
               if (ber_next == BER_THR) hi_ber_d = 1'b1;
            end
         end
         default: state_d = ST_RESET;
      endcase

      if (i_restart) begin
         state_d    = ST_RESET;
         relock_inc = (state_q != ST_RESET);
      end

      // Entry housekeeping keyed on the chosen next state.
      if (state_d == ST_RESET) begin
         if (i_restart || state_q != ST_RESET) rst_tmr_d = '0;
         lock_tmr_d = '0;
         win_tmr_d  = '0;
         ber_cnt_d  = '0;
         hbw_cnt_d  = '0;
         hi_ber_d   = 1'b0;
      end else if (state_d == ST_WAIT_LOCK && state_q != ST_WAIT_LOCK) begin
         lock_tmr_d = '0;
         hi_ber_d   = 1'b0;
      end else if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
         win_tmr_d = '0;
         ber_cnt_d = '0;
         hbw_cnt_d = '0;
         hi_ber_d  = 1'b0;
      end

      relock_d      = (relock_inc && relock_q != '1) ? relock_q + 1'b1 : relock_q;
      aligner_rst_d = (state_d == ST_RESET);
      status_d      = (state_d == ST_LOCKED) && !hi_ber_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RESET;
         rst_tmr_q     <= '0;
         lock_tmr_q    <= '0;
         win_tmr_q     <= '0;
         ber_cnt_q     <= '0;
         hbw_cnt_q     <= '0;
         hi_ber_q      <= 1'b0;
         aligner_rst_q <= 1'b1;
         status_q      <= 1'b0;
         relock_q      <= '0;
      end else begin
         state_q       <= state_d;
         rst_tmr_q     <= rst_tmr_d;
         lock_tmr_q    <= lock_tmr_d;
         win_tmr_q     <= win_tmr_d;
         ber_cnt_q     <= ber_cnt_d;
         hbw_cnt_q     <= hbw_cnt_d;
         hi_ber_q      <= hi_ber_d;
         aligner_rst_q <= aligner_rst_d;
         status_q      <= status_d;
         relock_q      <= relock_d;
      end
   end

   assign o_aligner_rst  = aligner_rst_q;
   assign o_rx_hi_ber    = hi_ber_q;
   assign o_rx_status    = status_q;
   assign o_relock_count = relock_q;
   assign o_state        = state_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Scenario bench for the RX link controller; expected snapshots are queued when
// stimulus is applied and popped against the registered outputs after the edge.
module tb_eth_phy_10g_rx_link_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  hdr;
   logic        lock;
   logic        restart;
   logic        o_aligner_rst;
   logic        o_rx_hi_ber;
   logic        o_rx_status;
   logic [15:0] o_relock_count;
   logic [1:0]  o_state;
   logic [20:0] obs;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct {
      string       tag;
      logic [20:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   eth_phy_10g_rx_link_ctrl #(
      .HDR_WIDTH(2), .BER_WINDOW(100), .BER_THRESH(4), .LOCK_TIMEOUT(50),
      .RST_PULSE(4), .HI_BER_WINDOWS(2), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .i_serdes_rx_hdr_align(hdr), .i_rx_block_lock(lock),
      .i_restart(restart), .o_aligner_rst(o_aligner_rst), .o_rx_hi_ber(o_rx_hi_ber),
      .o_rx_status(o_rx_status), .o_relock_count(o_relock_count), .o_state(o_state)
   );

   always #5 clk = ~clk;

   always_comb obs = {o_state, o_aligner_rst, o_rx_hi_ber, o_rx_status, o_relock_count};

   // Snapshot layout: {state, aligner_rst, hi_ber, status, relock_count}
   function automatic logic [20:0] ex(logic [1:0] st, logic arst, logic hb, logic stat,
                                      logic [15:0] cnt);
      return {st, arst, hb, stat, cnt};
   endfunction

   task automatic tick(int unsigned n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; lock = 1'b0; restart = 1'b0; hdr = 2'b01;
      tick(3);
      exp_q.push_back('{"reset_hold", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      rst = 1'b0;
      tick(2);
      exp_q.push_back('{"reset_pulse", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"reset_to_wait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_lock_acquire();
      lock = 1'b1;
      exp_q.push_back('{"lock_acquire", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_ber_threshold();
      hdr = 2'b00; tick(3);
      hdr = 2'b01; tick(6);
      exp_q.push_back('{"ber_below_thresh", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      hdr = 2'b00;
      exp_q.push_back('{"ber_at_thresh", ex(2'd2, 1'b0, 1'b1, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      hdr = 2'b01; tick(88);
      exp_q.push_back('{"hiber_window_close", ex(2'd2, 1'b0, 1'b1, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(98);
      exp_q.push_back('{"clean_window_hold", ex(2'd2, 1'b0, 1'b1, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"clean_window_clear", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_hiber_realign();
      hdr = 2'b00; tick(4);
      hdr = 2'b01; tick(95);
      exp_q.push_back('{"first_hiber_window", ex(2'd2, 1'b0, 1'b1, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      hdr = 2'b00; tick(4);
      hdr = 2'b01; tick(95);
      exp_q.push_back('{"hiber_realign", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd1)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      lock = 1'b0;
      tick(3);
      exp_q.push_back('{"realign_to_wait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd1)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_lock_timeout();
      tick(48);
      exp_q.push_back('{"timeout_still_wait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd1)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"timeout_reset", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd2)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(2);
      exp_q.push_back('{"timeout_pulse", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd2)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"timeout_rewait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd2)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(49);
      exp_q.push_back('{"timeout_repeat", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(4);
   endtask

   task automatic test_wrap_edge();
      lock = 1'b1; hdr = 2'b01;
      exp_q.push_back('{"wrap_relock", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(96);
      hdr = 2'b00; tick(2);
      exp_q.push_back('{"wrap_pre", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"wrap_counted", ex(2'd2, 1'b0, 1'b1, 1'b0, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      lock = 1'b0; hdr = 2'b01;
      exp_q.push_back('{"lock_drop", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_restart();
      lock = 1'b1;
      exp_q.push_back('{"restart_prelock", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd3)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      restart = 1'b1;
      exp_q.push_back('{"restart_enter", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd4)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      tick(8);
      exp_q.push_back('{"restart_held_once", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd4)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      restart = 1'b0;
      tick(2);
      exp_q.push_back('{"restart_pulse", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd4)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"restart_wait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd4)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"restart_relock", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd4)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   task automatic test_rst_mid();
      hdr = 2'b00; tick(2);
      rst = 1'b1;
      exp_q.push_back('{"rst_mid_locked", ex(2'd0, 1'b1, 1'b0, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      rst = 1'b0; hdr = 2'b01;
      tick(3);
      exp_q.push_back('{"post_rst_wait", ex(2'd1, 1'b0, 1'b0, 1'b0, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
      exp_q.push_back('{"post_rst_lock", ex(2'd2, 1'b0, 1'b0, 1'b1, 16'd0)});
      tick();
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, obs, e.v); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_lock_acquire();
      test_ber_threshold();
      test_hiber_realign();
      test_lock_timeout();
      test_wrap_edge();
      test_restart();
      test_rst_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
